// File: rtl/memory_access.sv
// MEM stage: issues loads/stores on the data bus, holds the pipeline while a
// transaction is outstanding, and aligns/extends load data for writeback.
module memory_access #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int CTL_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    // EX->MEM bundle; ctl[0]=mem_read, ctl[1]=mem_write, ctl[3:2]=msize, ctl[4]=mem_unsigned
    input  logic [ADDR_W-1:0]     dataE_pc,
    input  logic [31:0]           dataE_raw_instr,
    input  logic [DATA_W-1:0]     dataE_alu_out,
    input  logic [CTL_W-1:0]      dataE_ctl,
    input  logic [4:0]            dataE_dst,
    input  logic                  dataE_valid,
    input  logic [DATA_W-1:0]     dataE_mem_write_data,
    input  logic                  dresp_addr_ok,
    input  logic                  dresp_data_ok,
    input  logic [DATA_W-1:0]     dresp_data,
    output logic                  dreq_valid,
    output logic [ADDR_W-1:0]     dreq_addr,
    output logic [1:0]            dreq_size,
    output logic [DATA_W/8-1:0]   dreq_strobe,
    output logic [DATA_W-1:0]     dreq_data,
    output logic                  stall,
    output logic                  misalign,
    output logic [ADDR_W-1:0]     dataM_nxt_pc,
    output logic [31:0]           dataM_nxt_raw_instr,
    output logic [DATA_W-1:0]     dataM_nxt_result,
    output logic [CTL_W-1:0]      dataM_nxt_ctl,
    output logic [4:0]            dataM_nxt_dst,
    output logic                  dataM_nxt_valid
);

    localparam int STRB_W  = DATA_W / 8;
    localparam int OFF_W   = $clog2(STRB_W);
    localparam int CTL_RD  = 0;
    localparam int CTL_WR  = 1;
    localparam int CTL_SZ  = 2;
    localparam int CTL_UNS = 4;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_nxt;
    logic   capture;

    logic [ADDR_W-1:0] h_pc;
    logic [31:0]       h_raw;
    logic [DATA_W-1:0] h_alu;
    logic [CTL_W-1:0]  h_ctl;
    logic [4:0]        h_dst;
    logic [DATA_W-1:0] h_wdata;

    logic [ADDR_W-1:0] cur_pc;
    logic [31:0]       cur_raw;
    logic [DATA_W-1:0] cur_alu;
    logic [CTL_W-1:0]  cur_ctl;
    logic [4:0]        cur_dst;
    logic [DATA_W-1:0] cur_wdata;
    logic              cur_rd, cur_wr, cur_uns, mem_op, aligned, ext;
    logic [1:0]        cur_sz;
    logic [ADDR_W-1:0] addr;
    logic [OFF_W-1:0]  off;
    logic [STRB_W-1:0] strb_base;
    logic [DATA_W-1:0] lane, load_val;
    logic              unused;

    assign unused = dresp_addr_ok;

    // The op being served comes from the live bundle in IDLE and the held copy in BUSY.
    always_comb begin
        cur_pc    = (state == BUSY) ? h_pc    : dataE_pc;
        cur_raw   = (state == BUSY) ? h_raw   : dataE_raw_instr;
        cur_alu   = (state == BUSY) ? h_alu   : dataE_alu_out;
        cur_ctl   = (state == BUSY) ? h_ctl   : dataE_ctl;
        cur_dst   = (state == BUSY) ? h_dst   : dataE_dst;
        cur_wdata = (state == BUSY) ? h_wdata : dataE_mem_write_data;

        cur_rd  = cur_ctl[CTL_RD];
        cur_wr  = cur_ctl[CTL_WR];
        cur_sz  = cur_ctl[CTL_SZ+1:CTL_SZ];
        cur_uns = cur_ctl[CTL_UNS];
        mem_op  = (state == BUSY) || (dataE_valid && (cur_rd || cur_wr));

        addr = cur_alu[ADDR_W-1:0];
        off  = addr[OFF_W-1:0];
        case (cur_sz)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = ~addr[0];
            2'd2:    aligned = (addr[1:0] == 2'b00);
            default: aligned = (addr[2:0] == 3'b000);
        endcase
        strb_base = STRB_W'((16'd1 << (5'd1 << cur_sz)) - 16'd1);

        lane = dresp_data >> {off, 3'b000};
        case (cur_sz)
            2'd0: begin
                ext      = ~cur_uns & lane[7];
                load_val = {{(DATA_W-8){ext}}, lane[7:0]};
            end
            2'd1: begin
                ext      = ~cur_uns & lane[15];
                load_val = {{(DATA_W-16){ext}}, lane[15:0]};
            end
            2'd2: begin
                ext      = ~cur_uns & lane[31];
                load_val = {{(DATA_W-32){ext}}, lane[31:0]};
            end
            default: begin
                ext      = 1'b0;
                load_val = lane;
            end
        endcase
    end

    always_comb begin
        state_nxt           = state;
        capture             = 1'b0;
        dreq_valid          = 1'b0;
        dreq_addr           = addr;
        dreq_size           = cur_sz;
        // read has priority when both mem_read and mem_write are set
        dreq_strobe         = (cur_wr && !cur_rd) ? (strb_base << off) : '0;
        dreq_data           = cur_wdata << {off, 3'b000};
        stall               = 1'b0;
        misalign            = 1'b0;
        dataM_nxt_pc        = cur_pc;
        dataM_nxt_raw_instr = cur_raw;
        dataM_nxt_ctl       = cur_ctl;
        dataM_nxt_dst       = cur_dst;
        dataM_nxt_result    = cur_alu;
        dataM_nxt_valid     = 1'b0;

        case (state)
            IDLE: begin
                if (!mem_op) begin
                    dataM_nxt_valid = dataE_valid;
                end else if (!aligned) begin
                    dataM_nxt_valid  = 1'b1;
                    dataM_nxt_result = '0;
                    misalign         = 1'b1;
                end else begin
                    dreq_valid = 1'b1;
                    if (dresp_data_ok) begin
                        dataM_nxt_valid = 1'b1;
                        if (cur_rd) dataM_nxt_result = load_val;
                    end else begin
                        stall     = 1'b1;
                        capture   = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                dreq_valid = 1'b1;
                stall      = 1'b1;
                if (dresp_data_ok) begin
                    stall           = 1'b0;
                    dataM_nxt_valid = 1'b1;
                    if (cur_rd) dataM_nxt_result = load_val;
                    state_nxt       = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            h_pc    <= '0;
            h_raw   <= '0;
            h_alu   <= '0;
            h_ctl   <= '0;
            h_dst   <= '0;
            h_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                h_pc    <= dataE_pc;
                h_raw   <= dataE_raw_instr;
                h_alu   <= dataE_alu_out;
                h_ctl   <= dataE_ctl;
                h_dst   <= dataE_dst;
                h_wdata <= dataE_mem_write_data;
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed vector table, random ops
// against a behavioural model, back-to-back and reset-abort sequences.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] dataE_pc;
    logic [31:0] dataE_raw_instr;
    logic [63:0] dataE_alu_out;
    logic [15:0] dataE_ctl;
    logic [4:0]  dataE_dst;
    logic        dataE_valid;
    logic [63:0] dataE_mem_write_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        stall;
    logic        misalign;
    logic [63:0] dataM_nxt_pc;
    logic [31:0] dataM_nxt_raw_instr;
    logic [63:0] dataM_nxt_result;
    logic [15:0] dataM_nxt_ctl;
    logic [4:0]  dataM_nxt_dst;
    logic        dataM_nxt_valid;

    memory_access #(.ADDR_W(64), .DATA_W(64), .CTL_W(16)) dut (
        .clk(clk), .reset(reset),
        .dataE_pc(dataE_pc), .dataE_raw_instr(dataE_raw_instr),
        .dataE_alu_out(dataE_alu_out), .dataE_ctl(dataE_ctl),
        .dataE_dst(dataE_dst), .dataE_valid(dataE_valid),
        .dataE_mem_write_data(dataE_mem_write_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .stall(stall), .misalign(misalign),
        .dataM_nxt_pc(dataM_nxt_pc), .dataM_nxt_raw_instr(dataM_nxt_raw_instr),
        .dataM_nxt_result(dataM_nxt_result), .dataM_nxt_ctl(dataM_nxt_ctl),
        .dataM_nxt_dst(dataM_nxt_dst), .dataM_nxt_valid(dataM_nxt_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] alu;
        logic        rd, wr, uns;
        logic [1:0]  msz;
        logic [63:0] wdata, rdata;
        int unsigned lat;
        logic [63:0] exp_res;
        logic        exp_mis;
        logic [7:0]  exp_strb;
        logic [63:0] exp_wd;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    always @(negedge clk) if (dataM_nxt_valid) pulses++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: derived from byte arithmetic on the address, not from the RTL.
    function automatic logic [63:0] model_result(vec_t v);
        int unsigned bytes = 1 << v.msz;
        int unsigned off   = int'(v.alu % 8);
        logic [63:0] mask, lane;
        if (!(v.rd || v.wr)) return v.alu;
        if (v.alu % bytes != 0) return 64'd0;
        if (!v.rd) return v.alu;
        lane = v.rdata >> (off * 8);
        mask = (bytes == 8) ? {64{1'b1}} : ((64'd1 << (bytes * 8)) - 64'd1);
        lane = lane & mask;
        if (!v.uns && lane[bytes*8-1]) lane = lane | ~mask;
        return lane;
    endfunction

    function automatic vec_t model_fill(vec_t v);
        int unsigned bytes = 1 << v.msz;
        int unsigned off   = int'(v.alu % 8);
        vec_t r = v;
        r.exp_res  = model_result(v);
        r.exp_mis  = (v.rd || v.wr) && (v.alu % bytes != 0);
        r.exp_strb = (v.wr && !v.rd) ? 8'(((1 << bytes) - 1) << off) : 8'd0;
        r.exp_wd   = v.wdata << (off * 8);
        return r;
    endfunction

    function automatic vec_t mk(string name, logic [63:0] alu, logic rd, logic wr, logic uns,
                                logic [1:0] msz, logic [63:0] wdata, logic [63:0] rdata,
                                int unsigned lat, logic [63:0] res, logic mis,
                                logic [7:0] strb, logic [63:0] wd);
        vec_t v;
        v.name = name; v.alu = alu; v.rd = rd; v.wr = wr; v.uns = uns; v.msz = msz;
        v.wdata = wdata; v.rdata = rdata; v.lat = lat; v.exp_res = res;
        v.exp_mis = mis; v.exp_strb = strb; v.exp_wd = wd;
        return v;
    endfunction

    task automatic idle_inputs();
        dataE_valid   = 1'b0;
        dataE_ctl     = '0;
        dresp_data_ok = 1'b0;
    endtask

    // Entered just after a rising edge; returns just after the edge that ends the op.
    task automatic run_op(input vec_t v);
        logic [63:0] pc  = {$urandom, $urandom};
        logic [4:0]  dst = 5'($urandom);
        logic        mem = v.rd || v.wr;
        logic        go  = mem && !v.exp_mis;
        dataE_pc             = pc;
        dataE_raw_instr      = $urandom;
        dataE_alu_out        = v.alu;
        dataE_ctl            = {11'b0, v.uns, v.msz, v.wr, v.rd};
        dataE_dst            = dst;
        dataE_valid          = 1'b1;
        dataE_mem_write_data = v.wdata;
        dresp_data           = v.rdata;
        dresp_data_ok        = (v.lat == 0);
        if (go) begin
            for (int unsigned i = 0; i < v.lat; i++) begin
                @(negedge clk);
                check({v.name, ".stall"}, 64'(stall), 64'd1);
                check({v.name, ".wait_valid"}, 64'(dataM_nxt_valid), 64'd0);
                check({v.name, ".wait_dreq_valid"}, 64'(dreq_valid), 64'd1);
                check({v.name, ".wait_addr"}, dreq_addr, v.alu);
                check({v.name, ".wait_strobe"}, 64'(dreq_strobe), 64'(v.exp_strb));
                @(posedge clk); #1;
                // upstream garbage during BUSY must not leak into the held request
                dataE_alu_out        = {$urandom, $urandom};
                dataE_pc             = {$urandom, $urandom};
                dataE_mem_write_data = {$urandom, $urandom};
                if (i == v.lat - 1) dresp_data_ok = 1'b1;
            end
        end
        @(negedge clk);
        check({v.name, ".valid"}, 64'(dataM_nxt_valid), 64'd1);
        check({v.name, ".result"}, dataM_nxt_result, v.exp_res);
        check({v.name, ".misalign"}, 64'(misalign), 64'(v.exp_mis));
        check({v.name, ".stall"}, 64'(stall), 64'd0);
        check({v.name, ".pc"}, dataM_nxt_pc, pc);
        check({v.name, ".dst"}, 64'(dataM_nxt_dst), 64'(dst));
        check({v.name, ".dreq_valid"}, 64'(dreq_valid), 64'(go));
        if (go) begin
            check({v.name, ".addr"}, dreq_addr, v.alu);
            check({v.name, ".size"}, 64'(dreq_size), 64'(v.msz));
            check({v.name, ".strobe"}, 64'(dreq_strobe), 64'(v.exp_strb));
            if (v.wr && !v.rd) check({v.name, ".wdata"}, dreq_data, v.exp_wd);
        end
        @(posedge clk); #1;
        dresp_data_ok = 1'b0;
    endtask

    task automatic idle_cycle(input string name);
        idle_inputs();
        @(negedge clk);
        check({name, ".idle_dreq_valid"}, 64'(dreq_valid), 64'd0);
        check({name, ".idle_valid"}, 64'(dataM_nxt_valid), 64'd0);
        check({name, ".idle_stall"}, 64'(stall), 64'd0);
        @(posedge clk); #1;
    endtask

    vec_t vecs[$];
    vec_t rv;
    int   p0;

    initial begin
        dataE_pc = '0; dataE_raw_instr = '0; dataE_alu_out = '0; dataE_dst = '0;
        dataE_mem_write_data = '0; dresp_addr_ok = 1'b0; dresp_data = '0;
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset.dreq_valid", 64'(dreq_valid), 64'd0);
        check("reset.stall", 64'(stall), 64'd0);
        check("reset.misalign", 64'(misalign), 64'd0);
        check("reset.valid", 64'(dataM_nxt_valid), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        //          name     alu          rd wr u sz wdata     rdata                    lat result                  mis strobe wd
        vecs.push_back(mk("alu",  64'h1234, 0, 0, 0, 0, 64'h0,    64'h0,                   0, 64'h1234,               0, 8'h00, 64'h0));
        vecs.push_back(mk("lb",   64'h1003, 1, 0, 0, 0, 64'h0,    64'h00000000_80000000,   3, 64'hFFFFFFFF_FFFFFF80,  0, 8'h00, 64'h0));
        vecs.push_back(mk("lbu",  64'h1003, 1, 0, 1, 0, 64'h0,    64'h00000000_80000000,   3, 64'h80,                 0, 8'h00, 64'h0));
        vecs.push_back(mk("sh",   64'h2006, 0, 1, 0, 1, 64'hBEEF, 64'h0,                   0, 64'h2006,               0, 8'hC0, 64'hBEEF0000_00000000));
        vecs.push_back(mk("lw_mis", 64'h3002, 1, 0, 0, 2, 64'h0,  64'hFFFF,                0, 64'h0,                  1, 8'h00, 64'h0));
        vecs.push_back(mk("lw",   64'h5004, 1, 0, 0, 2, 64'h0,    64'h87654321_00000000,   1, 64'hFFFFFFFF_87654321,  0, 8'h00, 64'h0));
        vecs.push_back(mk("lhu",  64'h5002, 1, 0, 1, 1, 64'h0,    64'h00000000_F00D0000,   2, 64'hF00D,               0, 8'h00, 64'h0));
        vecs.push_back(mk("ld",   64'h6000, 1, 0, 0, 3, 64'h0,    64'h01234567_89ABCDEF,   2, 64'h01234567_89ABCDEF,  0, 8'h00, 64'h0));
        vecs.push_back(mk("sb",   64'h7005, 0, 1, 0, 0, 64'h1AB,  64'h0,                   1, 64'h7005,               0, 8'h20, 64'h0001AB00_00000000));
        vecs.push_back(mk("rdwr", 64'h8001, 1, 1, 1, 0, 64'hFF,   64'h0000_0000_0000_5A00, 0, 64'h5A,                 0, 8'h00, 64'h0));
        vecs.push_back(mk("sd_mis", 64'h9004, 0, 1, 0, 3, 64'h1,  64'h0,                   0, 64'h0,                  1, 8'h00, 64'h0));

        foreach (vecs[i]) begin
            run_op(vecs[i]);
            idle_cycle(vecs[i].name);
        end

        for (int n = 0; n < 40; n++) begin
            int kind;
            rv.name  = "rand";
            rv.alu   = {$urandom, $urandom};
            rv.msz   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) rv.alu = rv.alu & ~(64'((1 << rv.msz) - 1));
            kind     = int'($urandom_range(0, 3));
            rv.rd    = (kind == 1) || (kind == 3);
            rv.wr    = (kind == 2) || (kind == 3);
            rv.uns   = 1'($urandom);
            rv.wdata = {$urandom, $urandom};
            rv.rdata = {$urandom, $urandom};
            rv.lat   = $urandom_range(0, 3);
            rv = model_fill(rv);
            run_op(rv);
            if ($urandom_range(0, 1) == 1) idle_cycle("rand");
        end
        idle_cycle("rand_end");

        // Back-to-back LD then SD: the second request launches right after the first data_ok.
        p0 = pulses;
        run_op(mk("b2b_ld", 64'h4000, 1, 0, 0, 3, 64'h0, 64'hCAFEF00D_12345678, 1,
                  64'hCAFEF00D_12345678, 0, 8'h00, 64'h0));
        run_op(mk("b2b_sd", 64'h4008, 0, 1, 0, 3, 64'h11223344_55667788, 64'h0, 2,
                  64'h4008, 0, 8'hFF, 64'h11223344_55667788));
        idle_cycle("b2b");
        check("b2b.pulses", 64'(pulses - p0), 64'd2);

        // Reset while BUSY, then a late data_ok must not complete the aborted op.
        p0 = pulses;
        dataE_alu_out = 64'hA000; dataE_ctl = {11'b0, 1'b0, 2'd2, 1'b0, 1'b1};
        dataE_valid = 1'b1; dresp_data_ok = 1'b0;
        @(negedge clk);
        check("rst.stall_before", 64'(stall), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1; dataE_valid = 1'b0; dataE_ctl = '0;
        @(negedge clk);
        check("rst.busy_dreq_valid", 64'(dreq_valid), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0; dresp_data_ok = 1'b1;
        @(negedge clk);
        check("rst.dreq_valid", 64'(dreq_valid), 64'd0);
        check("rst.valid", 64'(dataM_nxt_valid), 64'd0);
        check("rst.stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        dresp_data_ok = 1'b0;
        @(negedge clk);
        check("rst.no_pulse", 64'(pulses - p0), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
